serial_add_ctrl: RTL and testbench
==================================

Name: serial_add_ctrl

Overview:
- Bit-serial adder controller that sits directly upstream of the team's 1-bit full-adder cell and drives its a/b/cin inputs.
- Accepts two WIDTH-bit operands on a start strobe, presents one bit pair plus the registered carry to the cell per cycle (LSB first), and collects the cell's sum/carry outputs.
- Assembles the WIDTH-bit result and final carry-out, then signals completion.
- Trades adder area for latency in the lab datapath.

Parameters:
- WIDTH, 8, operand/result width in bits (legal range 2..32).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  load operands and begin; sampled only in IDLE.
- a  input  WIDTH  operand A, sampled on the accepted start.
- b  input  WIDTH  operand B, sampled on the accepted start.
- cin  input  1  initial carry-in, sampled on the accepted start.
- fa_a  output  1  bit to full-adder cell input a.
- fa_b  output  1  bit to full-adder cell input b.
- fa_cin  output  1  registered carry to full-adder cell input cin.
- fa_s  input  1  sum bit from the cell.
- fa_cout  input  1  carry-out from the cell.
- busy  output  1  high while state != IDLE.
- done  output  1  one-cycle completion pulse.
- sum  output  WIDTH  result, held until the next accepted start.
- cout  output  1  final carry-out, held with sum.

Behaviour:
- Clocking and reset:
  - One clock; reset is asynchronous and active-low (clk, rst_n).
  - rst_n low forces state=IDLE and clears all registers: busy, done, sum, cout, fa_a, fa_b, fa_cin, shift registers, carry, counter all 0.
  - Reset mid-operation aborts with no partial result.
- States: IDLE, RUN, DONE.
- IDLE:
  - fa_a, fa_b, fa_cin driven 0.
  - start=1 at an edge: a_sr<=a, b_sr<=b, carry<=cin, cnt<=0, sum_sr<=0, go to RUN.
- RUN:
  - fa_a=a_sr[0], fa_b=b_sr[0], fa_cin=carry, all combinational from registers only.
  - The cell is combinational, so fa_s/fa_cout are valid in the same cycle.
  - Each edge: sum_sr<={fa_s, sum_sr[WIDTH-1:1]}; carry<=fa_cout; a_sr, b_sr shift right with 0 fill; cnt<=cnt+1.
  - On the edge where cnt==WIDTH-1: sum<={fa_s, sum_sr[WIDTH-1:1]}, cout<=fa_cout, go to DONE.
  - cnt width is clog2(WIDTH)+1; it never wraps within an operation.
- DONE:
  - done=1 for exactly this one cycle; fa_* driven 0; next state IDLE unconditionally.
- Latency:
  - start accepted at edge 0 → RUN occupies cycles 1..WIDTH → done high in cycle WIDTH+1.
  - Next start is accepted in cycle WIDTH+2, so throughput is one operation per WIDTH+2 cycles.
- start handling:
  - start while busy=1 (RUN or DONE) is ignored; operands are not re-sampled.
  - Changes on a/b/cin after acceptance have no effect.
- Result: sum/cout equal {cout,sum} = a + b + cin (WIDTH+1-bit unsigned). They are stable from the done cycle until the edge after the next accepted start.
- busy = (state != IDLE), registered state decode.

Optional Feature:
- Macro: SERIAL_ADD_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), sampled with start.
  - sub=1 loads b_sr<=~b and forces carry<=1, ignoring cin, so sum = a − b mod 2^WIDTH.
  - In subtract mode cout=1 means no borrow (a ≥ b).
  - sub=0 gives addition identical to the base block.
- Not defined: no sub port; add-only behaviour as above.

Test Plan:
- WIDTH=8, a=0x5A, b=0x33, cin=0, start 1 cycle → busy high for 9 cycles; done pulses in cycle 9 after start edge; sum=0x8D, cout=0; fa_a sequence LSB-first 0,1,0,1,1,0,1,0.
- a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1; a=0xFF, b=0xFF, cin=1 → sum=0xFF, cout=1 (full carry ripple across all bits).
- start with a=0x01, b=0x01, then start re-asserted with a=0xF0 during RUN and again in DONE → both ignored; result sum=0x02, cout=0; sum held after done until the next start.
- rst_n low in cycle 4 of RUN (asynchronous, mid-cycle) → busy, done, fa_*, sum, cout read 0 immediately; after release, new start with a=0x10, b=0x20 → sum=0x30 with normal latency.
- Back-to-back: start held high continuously with a=0x03, b=0x04 → accepted every 10 cycles; done pulses at a 10-cycle period, each with sum=0x07.
- SERIAL_ADD_SUB_EN defined: sub=1, a=0x10, b=0x01 → sum=0x0F, cout=1; sub=1, a=0x01, b=0x02 → sum=0xFF, cout=0.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder controller. It drives an external
// combinational 1-bit full-adder cell one bit pair per cycle, LSB first, and
// collects the cell's sum and carry outputs.
//
// Operation: an accepted start loads the operands. RUN then lasts WIDTH
// cycles, and DONE pulses for one cycle. One operation completes every
// WIDTH+2 cycles.
//
// Optional feature: define SERIAL_ADD_SUB_EN to add the sub_i port.
// With sub_i=1 the block computes a - b mod 2^WIDTH by adding ~b with a
// forced carry-in of 1. In that mode cout_o=1 means no borrow.
//
// Ports:
//   clk, rst_n           clock (rising edge), async active-low reset
//   start_i              load operands and begin; only sampled in IDLE
//   a_i, b_i, cin_i      operands and carry-in, sampled on accepted start
//   sub_i                (SERIAL_ADD_SUB_EN only) subtract select
//   fa_a_o, fa_b_o       operand bits to the full-adder cell
//   fa_cin_o             registered carry to the full-adder cell
//   fa_s_i, fa_cout_i    sum / carry back from the cell
//   busy_o               state != IDLE
//   done_o               one-cycle completion pulse
//   sum_o, cout_o        result, held until the edge after the next start
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub_i,
`endif
  output logic             fa_a_o,
  output logic             fa_b_o,
  output logic             fa_cin_o,
  input  logic             fa_s_i,
  input  logic             fa_cout_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] sum_sr_q, sum_sr_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic             run;
  logic [WIDTH-1:0] b_load;
  logic             c_load;
  logic [WIDTH-1:0] sum_shift;

  // Subtraction is two's-complement addition: invert b and force carry-in to 1.
`ifdef SERIAL_ADD_SUB_EN
  assign b_load = sub_i ? ~b_i : b_i;
  assign c_load = sub_i ? 1'b1 : cin_i;
`else
  assign b_load = b_i;
  assign c_load = cin_i;
`endif

  // The cell is combinational, so its result for the current bit is already
  // valid here and enters at the MSB end of the shift register.
  assign sum_shift = {fa_s_i, sum_sr_q[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      sum_sr_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      sum_sr_q <= sum_sr_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    sum_sr_d = sum_sr_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          a_sr_d   = a_i;
          b_sr_d   = b_load;
          carry_d  = c_load;
          cnt_d    = '0;
          sum_sr_d = '0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        sum_sr_d = sum_shift;
        carry_d  = fa_cout_i;
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        // Last bit: publish the result directly. sum_q keeps the previous
        // result visible throughout RUN.
        if (cnt_q == CW'(WIDTH - 1)) begin
          sum_d   = sum_shift;
          cout_d  = fa_cout_i;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign run      = (state_q == S_RUN);
  assign fa_a_o   = run & a_sr_q[0];
  assign fa_b_o   = run & b_sr_q[0];
  assign fa_cin_o = run & carry_q;
  assign busy_o   = (state_q != S_IDLE);
  assign done_o   = (state_q == S_DONE);
  assign sum_o    = sum_q;
  assign cout_o   = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl. The bench models the full-adder
// cell and uses a reference model that is plain integer addition.
module tb_serial_add_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         cin = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
`ifdef SERIAL_ADD_SUB_EN
  logic         sub = 1'b0;
`endif
  logic         fa_a, fa_b, fa_cin, fa_s, fa_cout, busy, done, cout;
  logic [W-1:0] sum;

  int n_chk = 0;
  int n_fail = 0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .a_i(a), .b_i(b), .cin_i(cin),
`ifdef SERIAL_ADD_SUB_EN
    .sub_i(sub),
`endif
    .fa_a_o(fa_a), .fa_b_o(fa_b), .fa_cin_o(fa_cin), .fa_s_i(fa_s),
    .fa_cout_i(fa_cout), .busy_o(busy), .done_o(done), .sum_o(sum), .cout_o(cout)
  );

  // Combinational 1-bit full-adder cell.
  assign fa_s    = fa_a ^ fa_b ^ fa_cin;
  assign fa_cout = (fa_a & fa_b) | (fa_cin & (fa_a ^ fa_b));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Carry entering bit i is bit i of the sum of the operands' low i bits.
  function automatic logic [W-1:0] carries(input logic [W-1:0] x, input logic [W-1:0] y,
                                            input logic c);
    logic [63:0] m, s;
    for (int i = 0; i < W; i++) begin
      m = (64'd1 << i) - 64'd1;
      s = (64'(x) & m) + (64'(y) & m) + 64'(c);
      carries[i] = s[i];
    end
  endfunction

  // Run one operation from a negedge in IDLE. The task returns at a negedge
  // in IDLE. When poke is set, start is re-asserted with other operands
  // during RUN and again during DONE.
  task automatic run_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc,
                        input logic xs, input bit poke);
    logic [W-1:0] ya, seq_a, seq_b, seq_c;
    logic         yc;
    logic [63:0]  ref_full;
    int           bad;
    ya = xs ? ~xb : xb;
    yc = xs ? 1'b1 : xc;
    ref_full = 64'(xa) + 64'(ya) + 64'(yc);
    bad = 0;
    start = 1'b1; a = xa; b = xb; cin = xc;
`ifdef SERIAL_ADD_SUB_EN
    sub = xs;
`endif
    @(posedge clk);
    #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      seq_a[i] = fa_a; seq_b[i] = fa_b; seq_c[i] = fa_cin;
      if (!busy || done) bad++;
      if (poke && i == 2) begin start = 1'b1; a = 8'hF0; end
      if (poke && i == 3) start = 1'b0;
    end
    chk("run_busy", 64'(bad), 64'd0);
    chk("fa_a_seq", 64'(seq_a), 64'(xa));
    chk("fa_b_seq", 64'(seq_b), 64'(ya));
    chk("fa_cin_seq", 64'(seq_c), 64'(carries(xa, ya, yc)));
    @(negedge clk);
    chk("done_pulse", 64'({done, busy}), 64'b11);
    chk("result", 64'({cout, sum}), ref_full & ((64'd1 << (W + 1)) - 64'd1));
    chk("fa_idle_done", 64'({fa_a, fa_b, fa_cin}), 64'd0);
    if (poke) begin start = 1'b1; a = 8'hF0; end
    @(negedge clk);
    start = 1'b0;
    chk("after_done", 64'({done, busy}), 64'b00);
    chk("result_held", 64'({cout, sum}), ref_full & ((64'd1 << (W + 1)) - 64'd1));
  endtask

  initial begin
    int prev, ndone;
    logic [W-1:0] ra, rb;
    logic rc, rs;

    repeat (2) @(negedge clk);
    chk("reset_state", 64'({busy, done, fa_a, fa_b, fa_cin, cout, sum}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(8'h5A, 8'h33, 1'b0, 1'b0, 1'b0);
    chk("tp_5a_33", 64'({cout, sum}), 64'h08D);
    run_op(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
    chk("tp_ff_01", 64'({cout, sum}), 64'h100);
    run_op(8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0);
    chk("tp_ff_ff_c", 64'({cout, sum}), 64'h1FF);

    // Re-asserting start in RUN and in DONE must be ignored.
    run_op(8'h01, 8'h01, 1'b0, 1'b0, 1'b1);
    chk("tp_ignore", 64'({cout, sum}), 64'h002);
    repeat (5) @(negedge clk);
    chk("tp_hold", 64'({busy, cout, sum}), 64'h002);

    // Asynchronous reset in the middle of the fourth RUN cycle.
    start = 1'b1; a = 8'h77; b = 8'h66; cin = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("midrun_reset", 64'({busy, done, fa_a, fa_b, fa_cin, cout, sum}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(8'h10, 8'h20, 1'b0, 1'b0, 1'b0);
    chk("post_reset", 64'({cout, sum}), 64'h030);

    // Holding start high continuously: one operation per W+2 cycles.
    start = 1'b1; a = 8'h03; b = 8'h04; cin = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
    sub = 1'b0;
`endif
    prev = -1; ndone = 0;
    for (int c = 1; c <= 39; c++) begin
      @(negedge clk);
      if (done) begin
        chk("b2b_sum", 64'({cout, sum}), 64'h007);
        if (prev < 0) chk("b2b_first", 64'(c), 64'(W + 1));
        else          chk("b2b_period", 64'(c - prev), 64'(W + 2));
        prev = c;
        ndone++;
      end
    end
    start = 1'b0;
    chk("b2b_count", 64'(ndone), 64'd4);
    @(negedge clk);
    chk("b2b_idle", 64'(busy), 64'd0);

`ifdef SERIAL_ADD_SUB_EN
    run_op(8'h10, 8'h01, 1'b0, 1'b1, 1'b0);
    chk("sub_10_01", 64'({cout, sum}), 64'h10F);
    run_op(8'h01, 8'h02, 1'b0, 1'b1, 1'b0);
    chk("sub_01_02", 64'({cout, sum}), 64'h0FF);
`endif

    for (int k = 0; k < 30; k++) begin
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
`ifdef SERIAL_ADD_SUB_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      run_op(ra, rb, rc, rs, (k % 5) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
